// File: rtl/uart_resp_tx.sv
// UART response transmitter: builds ack/error/read frames and sends them 8N1.
// Define UART_RESP_CHKSUM_EN to append an XOR checksum byte to every frame.
module uart_resp_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DONE,
   input  logic        OK,
   input  logic        FAIL_IN,
   input  logic        STATE_R_IN,
   input  logic [31:0] DATA_IN,
   output logic        TX,
   output logic        BUSY,
   output logic        TX_DONE,
   output logic        DROP
);

`ifdef UART_RESP_CHKSUM_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif

   localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e              state_q, state_d;
   logic [NB-1:0][7:0]  frame_q, frame_d, cap_frame;
   logic [2:0]          rem_q, rem_d, cap_len;
   logic [2:0]          bit_q, bit_d, nxt_bit;
   logic [15:0]         cnt_q, cnt_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                txd_q, txd_d;
   logic                drop_q, drop_d;
   logic                bit_end;

   assign bit_end = (cnt_q == CNT_MAX);
   assign nxt_bit = bit_q + 3'd1;

   // Frame byte 0 goes out first; later bytes shift down into slot 0.
   always_comb begin
`ifdef UART_RESP_CHKSUM_EN
      logic [7:0] chk;
`endif
      cap_frame = '0;
      cap_len   = 3'd1;
      if (FAIL_IN) begin
         cap_frame[0] = 8'h45;
      end else if (OK && STATE_R_IN) begin
         cap_frame[0] = 8'h52;
         cap_frame[1] = DATA_IN[31:24];
         cap_frame[2] = DATA_IN[23:16];
         cap_frame[3] = DATA_IN[15:8];
         cap_frame[4] = DATA_IN[7:0];
         cap_len      = 3'd5;
      end else if (OK) begin
         cap_frame[0] = 8'h4B;
      end else begin
         cap_frame[0] = 8'h45;
      end
`ifdef UART_RESP_CHKSUM_EN
      chk = 8'h00;
      for (int i = 0; i < 5; i++) begin
         chk = chk ^ cap_frame[i];
      end
      if (cap_len == 3'd5) begin
         cap_frame[5] = chk;
      end else begin
         cap_frame[1] = chk;
      end
      cap_len = cap_len + 3'd1;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         frame_q <= '0;
         rem_q   <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         txd_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         rem_q   <= rem_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         txd_q   <= txd_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (DONE) state_d = START;
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && bit_q == 3'd7) state_d = STOP;
         STOP:  if (bit_end) state_d = (rem_q == 3'd0) ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_d = frame_q;
      rem_d   = rem_q;
      bit_d   = bit_q;
      cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
      tx_d    = tx_q;
      busy_d  = busy_q;
      txd_d   = 1'b0;
      drop_d  = (state_q != IDLE) && DONE;
      unique case (state_q)
         IDLE: begin
            cnt_d = 16'd0;
            if (DONE) begin
               frame_d = cap_frame;
               rem_d   = cap_len - 3'd1;
               bit_d   = 3'd0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               bit_d = 3'd0;
               tx_d  = frame_q[0][0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  tx_d = 1'b1;
               end else begin
                  bit_d = nxt_bit;
                  tx_d  = frame_q[0][nxt_bit];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (rem_q == 3'd0) begin
                  tx_d   = 1'b1;
                  busy_d = 1'b0;
                  txd_d  = 1'b1;
               end else begin
                  rem_d   = rem_q - 3'd1;
                  frame_d = {8'h00, frame_q[NB-1:1]};
                  tx_d    = 1'b0;
               end
            end
         end
         default: begin
            tx_d = 1'b1;
         end
      endcase
   end

   assign TX      = tx_q;
   assign BUSY    = busy_q;
   assign TX_DONE = txd_q;
   assign DROP    = drop_q;

endmodule
